// File: rtl/cpu_mem_pkg.sv
// Shared sizing, default watch address and responder state encoding for the CPU memory bus.
// Imported by the CPU, the memory responder and the testbench.
package cpu_mem_pkg;

    localparam int ADDR_WIDTH         = 12;
    localparam int WORD_WIDTH         = 16;
    localparam int WORD_DEPTH         = 2 ** ADDR_WIDTH;
    localparam int DEFAULT_WATCH_ADDR = 99;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } mem_state_e;

endpackage

// File: rtl/sram_core.sv
// Single-port synchronous word store: one write port and one registered read port.
// The read register only updates when re_i is high.
module sram_core #(
    parameter int ADDR_WIDTH = 12,
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WORD_WIDTH-1:0] wdata_i,
    input  logic                  we_i,
    input  logic                  re_i,
    output logic [WORD_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WORD_WIDTH-1:0] mem_q [DEPTH];
    logic [WORD_WIDTH-1:0] rdata_q;

    // NOTE: the array is deliberately left out of reset so a reset keeps the loaded program.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: preload port feeds the store while the CPU is held (LOAD),
// then the CPU bus owns it (RUN); CPU writes to the watch address are mirrored out.
module mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = cpu_mem_pkg::ADDR_WIDTH,
    parameter int WORD_DEPTH = 2 ** ADDR_WIDTH,
    parameter int WORD_WIDTH = cpu_mem_pkg::WORD_WIDTH,
    parameter int WATCH_ADDR = cpu_mem_pkg::DEFAULT_WATCH_ADDR
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WORD_WIDTH-1:0] i_data,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_we,
    input  logic                  i_ce,
    output logic [WORD_WIDTH-1:0] o_data,
    input  logic                  i_ld_valid,
    output logic                  o_ld_ready,
    input  logic [ADDR_WIDTH-1:0] i_ld_addr,
    input  logic [WORD_WIDTH-1:0] i_ld_data,
    input  logic                  i_ld_done,
    output logic                  o_cpu_hold,
    output logic [ADDR_WIDTH:0]   o_ld_count,
    output logic [WORD_WIDTH-1:0] o_watch,
    output logic                  o_watch_vld
);

    localparam logic [ADDR_WIDTH:0]   LD_COUNT_MAX = (ADDR_WIDTH + 1)'(WORD_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] WATCH_MATCH  = ADDR_WIDTH'(WATCH_ADDR);

    mem_state_e            state_q, state_d;
    logic [ADDR_WIDTH:0]   ld_count_q, ld_count_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic [WORD_WIDTH-1:0] watch_q, watch_d;
    logic                  watch_vld_q, watch_vld_d;

    logic                  ld_fire, cpu_wr, cpu_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic                  mem_we, mem_re;

    assign o_ld_ready = (state_q == LOAD);
    assign ld_fire    = i_ld_valid & o_ld_ready;
    assign cpu_wr     = (state_q == RUN) & i_ce & i_we;
    assign cpu_rd     = (state_q == RUN) & i_ce & ~i_we;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d     = state_q;
        ld_count_d  = ld_count_q;
        watch_d     = watch_q;
        watch_vld_d = 1'b0;
        mem_addr    = i_addr;
        mem_wdata   = i_data;
        mem_we      = cpu_wr;
        mem_re      = cpu_rd;
        unique case (state_q)
            LOAD: begin
                mem_addr  = i_ld_addr;
                mem_wdata = i_ld_data;
                mem_we    = ld_fire;
                if (ld_fire && (ld_count_q != LD_COUNT_MAX)) begin
                    ld_count_d = ld_count_q + 1'b1;
                end
                if (i_ld_done) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cpu_wr && (i_addr == WATCH_MATCH)) begin
                    watch_d     = i_data;
                    watch_vld_d = 1'b1;
                end
            end
        endcase
        // Hold drops on the very edge that enters RUN.
        cpu_hold_d = (state_d == LOAD);
    end

    // NOTE: state registers use non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= LOAD;
            ld_count_q  <= '0;
            cpu_hold_q  <= 1'b1;
            watch_q     <= '0;
            watch_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_count_q  <= ld_count_d;
            cpu_hold_q  <= cpu_hold_d;
            watch_q     <= watch_d;
            watch_vld_q <= watch_vld_d;
        end
    end

    sram_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_sram_core (
        .clk     (clk),
        .reset_n (reset_n),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .we_i    (mem_we & reset_n),
        .re_i    (mem_re),
        .rdata_o (o_data)
    );

    assign o_cpu_hold  = cpu_hold_q;
    assign o_ld_count  = ld_count_q;
    assign o_watch     = watch_q;
    assign o_watch_vld = watch_vld_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: preload, LOAD isolation, watch register,
// read-after-write, mid-run reset and preload counter saturation.
module tb_mem_responder;
    import cpu_mem_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b1;
    logic [WORD_WIDTH-1:0] i_data = '0;
    logic [ADDR_WIDTH-1:0] i_addr = '0;
    logic                  i_we = 1'b0;
    logic                  i_ce = 1'b0;
    logic [WORD_WIDTH-1:0] o_data;
    logic                  i_ld_valid = 1'b0;
    logic                  o_ld_ready;
    logic [ADDR_WIDTH-1:0] i_ld_addr = '0;
    logic [WORD_WIDTH-1:0] i_ld_data = '0;
    logic                  i_ld_done = 1'b0;
    logic                  o_cpu_hold;
    logic [ADDR_WIDTH:0]   o_ld_count;
    logic [WORD_WIDTH-1:0] o_watch;
    logic                  o_watch_vld;

    int total = 0;
    int bad   = 0;

    mem_responder dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_data      (i_data),
        .i_addr      (i_addr),
        .i_we        (i_we),
        .i_ce        (i_ce),
        .o_data      (o_data),
        .i_ld_valid  (i_ld_valid),
        .o_ld_ready  (o_ld_ready),
        .i_ld_addr   (i_ld_addr),
        .i_ld_data   (i_ld_data),
        .i_ld_done   (i_ld_done),
        .o_cpu_hold  (o_cpu_hold),
        .o_ld_count  (o_ld_count),
        .o_watch     (o_watch),
        .o_watch_vld (o_watch_vld)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_ce       = 1'b0;
        i_we       = 1'b0;
        i_ld_valid = 1'b0;
        i_ld_done  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic preload(input logic [ADDR_WIDTH-1:0] a, input logic [WORD_WIDTH-1:0] d);
        i_ld_valid = 1'b1;
        i_ld_addr  = a;
        i_ld_data  = d;
        tick();
        idle();
    endtask

    task automatic ld_done();
        i_ld_done = 1'b1;
        tick();
        idle();
    endtask

    task automatic cpu_write(input logic [ADDR_WIDTH-1:0] a, input logic [WORD_WIDTH-1:0] d);
        i_ce   = 1'b1;
        i_we   = 1'b1;
        i_addr = a;
        i_data = d;
        tick();
        idle();
    endtask

    task automatic cpu_read(input logic [ADDR_WIDTH-1:0] a);
        i_ce   = 1'b1;
        i_we   = 1'b0;
        i_addr = a;
        tick();
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (o_data !== 16'h0000) begin bad++; $display("FAIL reset_data: got %h want 0000", o_data); end
        total++; if (o_cpu_hold !== 1'b1) begin bad++; $display("FAIL reset_hold: got %b want 1", o_cpu_hold); end
        total++; if (o_ld_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", o_ld_ready); end
        total++; if (o_ld_count !== 13'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", o_ld_count); end
        total++; if (o_watch !== 16'h0000) begin bad++; $display("FAIL reset_watch: got %h want 0000", o_watch); end
        total++; if (o_watch_vld !== 1'b0) begin bad++; $display("FAIL reset_watch_vld: got %b want 0", o_watch_vld); end
    endtask

    task automatic test_load();
        preload(12'd0, 16'h0001);
        preload(12'd1, 16'h0002);
        preload(12'd2, 16'h0003);
        total++; if (o_ld_count !== 13'd3) begin bad++; $display("FAIL load_count: got %0d want 3", o_ld_count); end
        total++; if (o_cpu_hold !== 1'b1) begin bad++; $display("FAIL load_hold_before_done: got %b want 1", o_cpu_hold); end
        ld_done();
        total++; if (o_cpu_hold !== 1'b0) begin bad++; $display("FAIL load_hold_at_done: got %b want 0", o_cpu_hold); end
        total++; if (o_ld_ready !== 1'b0) begin bad++; $display("FAIL load_ready_run: got %b want 0", o_ld_ready); end
        total++; if (o_ld_count !== 13'd3) begin bad++; $display("FAIL load_count_run: got %0d want 3", o_ld_count); end
        cpu_read(12'd1);
        total++; if (o_data !== 16'h0002) begin bad++; $display("FAIL load_read1: got %h want 0002", o_data); end
    endtask

    task automatic test_load_isolation();
        do_reset();
        preload(12'd5, 16'h5A5A);
        cpu_write(12'd5, 16'hBEEF);
        total++; if (o_data !== 16'h0000) begin bad++; $display("FAIL iso_data_after_write: got %h want 0000", o_data); end
        cpu_read(12'd5);
        total++; if (o_data !== 16'h0000) begin bad++; $display("FAIL iso_data_after_read: got %h want 0000", o_data); end
        total++; if (o_ld_count !== 13'd1) begin bad++; $display("FAIL iso_count: got %0d want 1", o_ld_count); end
        ld_done();
        cpu_read(12'd5);
        total++; if (o_data !== 16'h5A5A) begin bad++; $display("FAIL iso_read5: got %h want 5a5a", o_data); end
    endtask

    task automatic test_valid_done();
        do_reset();
        i_ld_valid = 1'b1;
        i_ld_done  = 1'b1;
        i_ld_addr  = 12'd7;
        i_ld_data  = 16'h00AA;
        tick();
        idle();
        total++; if (o_ld_count !== 13'd1) begin bad++; $display("FAIL vd_count: got %0d want 1", o_ld_count); end
        total++; if (o_cpu_hold !== 1'b0) begin bad++; $display("FAIL vd_hold: got %b want 0", o_cpu_hold); end
        total++; if (o_ld_ready !== 1'b0) begin bad++; $display("FAIL vd_ready: got %b want 0", o_ld_ready); end
        // Load port must be dead in RUN: this word must be neither stored nor counted.
        preload(12'd7, 16'h7777);
        total++; if (o_ld_count !== 13'd1) begin bad++; $display("FAIL vd_count_run_ignored: got %0d want 1", o_ld_count); end
        cpu_read(12'd7);
        total++; if (o_data !== 16'h00AA) begin bad++; $display("FAIL vd_read7: got %h want 00aa", o_data); end
    endtask

    task automatic test_watch();
        cpu_write(12'd99, 16'd450);
        total++; if (o_watch !== 16'h01C2) begin bad++; $display("FAIL watch_value: got %h want 01c2", o_watch); end
        total++; if (o_watch_vld !== 1'b1) begin bad++; $display("FAIL watch_pulse: got %b want 1", o_watch_vld); end
        total++; if (o_data !== 16'h00AA) begin bad++; $display("FAIL watch_data_held: got %h want 00aa", o_data); end
        tick();
        total++; if (o_watch_vld !== 1'b0) begin bad++; $display("FAIL watch_pulse_end: got %b want 0", o_watch_vld); end
        cpu_write(12'd98, 16'h0777);
        total++; if (o_watch_vld !== 1'b0) begin bad++; $display("FAIL watch_addr98_pulse: got %b want 0", o_watch_vld); end
        total++; if (o_watch !== 16'h01C2) begin bad++; $display("FAIL watch_addr98_value: got %h want 01c2", o_watch); end
        i_ce = 1'b1; i_we = 1'b1; i_addr = 12'd99; i_data = 16'h0011;
        tick();
        total++; if (o_watch_vld !== 1'b1 || o_watch !== 16'h0011) begin bad++; $display("FAIL watch_b2b_first: got vld=%b val=%h want vld=1 val=0011", o_watch_vld, o_watch); end
        i_data = 16'h0022;
        tick();
        idle();
        total++; if (o_watch_vld !== 1'b1 || o_watch !== 16'h0022) begin bad++; $display("FAIL watch_b2b_second: got vld=%b val=%h want vld=1 val=0022", o_watch_vld, o_watch); end
        tick();
        total++; if (o_watch_vld !== 1'b0) begin bad++; $display("FAIL watch_b2b_end: got %b want 0", o_watch_vld); end
        cpu_read(12'd99);
        total++; if (o_data !== 16'h0022) begin bad++; $display("FAIL watch_mem99: got %h want 0022", o_data); end
    endtask

    task automatic test_read_after_write();
        cpu_read(12'd0);
        total++; if (o_data !== 16'h0001) begin bad++; $display("FAIL raw_pre_read0: got %h want 0001", o_data); end
        i_ce = 1'b1; i_we = 1'b1; i_addr = 12'd10; i_data = 16'h1234;
        tick();
        total++; if (o_data !== 16'h0001) begin bad++; $display("FAIL raw_data_at_write: got %h want 0001", o_data); end
        i_we = 1'b0;
        tick();
        total++; if (o_data !== 16'h1234) begin bad++; $display("FAIL raw_read10: got %h want 1234", o_data); end
        i_addr = 12'd0;
        tick();
        total++; if (o_data !== 16'h0001) begin bad++; $display("FAIL b2b_read0: got %h want 0001", o_data); end
        i_addr = 12'd1;
        tick();
        total++; if (o_data !== 16'h0002) begin bad++; $display("FAIL b2b_read1: got %h want 0002", o_data); end
        i_addr = 12'd2;
        tick();
        idle();
        total++; if (o_data !== 16'h0003) begin bad++; $display("FAIL b2b_read2: got %h want 0003", o_data); end
        i_addr = 12'd10;
        tick();
        total++; if (o_data !== 16'h0003) begin bad++; $display("FAIL idle_hold: got %h want 0003", o_data); end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        total++; if (o_cpu_hold !== 1'b1) begin bad++; $display("FAIL rst_run_hold: got %b want 1", o_cpu_hold); end
        total++; if (o_ld_count !== 13'd0) begin bad++; $display("FAIL rst_run_count: got %0d want 0", o_ld_count); end
        total++; if (o_watch !== 16'h0000) begin bad++; $display("FAIL rst_run_watch: got %h want 0000", o_watch); end
        total++; if (o_data !== 16'h0000) begin bad++; $display("FAIL rst_run_data: got %h want 0000", o_data); end
        total++; if (o_ld_ready !== 1'b1) begin bad++; $display("FAIL rst_run_ready: got %b want 1", o_ld_ready); end
        ld_done();
        cpu_read(12'd0);
        total++; if (o_data !== 16'h0001) begin bad++; $display("FAIL rst_run_read0: got %h want 0001", o_data); end
        cpu_read(12'd10);
        total++; if (o_data !== 16'h1234) begin bad++; $display("FAIL rst_run_read10: got %h want 1234", o_data); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < WORD_DEPTH; i++) begin
            i_ld_valid = 1'b1;
            i_ld_addr  = ADDR_WIDTH'(i);
            i_ld_data  = WORD_WIDTH'(i) + 16'h1000;
            tick();
        end
        idle();
        total++; if (o_ld_count !== 13'd4096) begin bad++; $display("FAIL sat_count_full: got %0d want 4096", o_ld_count); end
        total++; if (o_watch !== 16'h0000 || o_watch_vld !== 1'b0) begin bad++; $display("FAIL sat_watch_untouched: got val=%h vld=%b want 0000/0", o_watch, o_watch_vld); end
        preload(12'd0, 16'hFFFF);
        total++; if (o_ld_count !== 13'd4096) begin bad++; $display("FAIL sat_count_hold: got %0d want 4096", o_ld_count); end
        total++; if (o_cpu_hold !== 1'b1) begin bad++; $display("FAIL sat_hold: got %b want 1", o_cpu_hold); end
        ld_done();
        cpu_read(12'd0);
        total++; if (o_data !== 16'hFFFF) begin bad++; $display("FAIL sat_read0: got %h want ffff", o_data); end
        cpu_read(12'd4095);
        total++; if (o_data !== 16'h1FFF) begin bad++; $display("FAIL sat_read4095: got %h want 1fff", o_data); end
        cpu_read(12'd99);
        total++; if (o_data !== 16'h1063) begin bad++; $display("FAIL sat_read99: got %h want 1063", o_data); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_load_isolation();
        test_valid_done();
        test_watch();
        test_read_after_write();
        test_reset_mid_run();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU's single-port memory bus (`o_addr`/`o_data`/`o_we`/`o_ce` from the CPU, read data back on `i_data`). It holds a 4096×16 word store and a preload port. Through the preload port the bench or boot logic writes the program and data before releasing the CPU. It also has a watch register that captures CPU writes to one result address. It replaces the bare SRAM plus hierarchical `$readmemb` and memory peeking at the system level.

## Interface
- `ADDR_WIDTH`, 12: bus address width.
- `WORD_DEPTH`, 4096: words stored; equals 2**ADDR_WIDTH.
- `WORD_WIDTH`, 16: data width.
- `WATCH_ADDR`, 99: address whose CPU writes are mirrored to `o_watch`.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  synchronous reset, active low.
- `i_data`  in  WORD_WIDTH  CPU write data.
- `i_addr`  in  ADDR_WIDTH  CPU address.
- `i_we`  in  1  CPU write enable, qualified by `i_ce`.
- `i_ce`  in  1  CPU access strobe.
- `o_data`  out  WORD_WIDTH  read data to CPU.
- `i_ld_valid`  in  1  preload word valid.
- `o_ld_ready`  out  1  preload port accepting.
- `i_ld_addr`  in  ADDR_WIDTH  preload address.
- `i_ld_data`  in  WORD_WIDTH  preload data.
- `i_ld_done`  in  1  end of preload; sampled only in LOAD.
- `o_cpu_hold`  out  1  high means the CPU must stay in reset.
- `o_ld_count`  out  ADDR_WIDTH+1  words accepted since reset.
- `o_watch`  out  WORD_WIDTH  last value the CPU wrote to WATCH_ADDR.
- `o_watch_vld`  out  1  one-cycle pulse when `o_watch` updates.

## Operation
- States: LOAD, RUN.
- Reset state is LOAD.
- LOAD → RUN on a rising edge with `i_ld_done`=1.
- RUN has no exit except reset.
- LOAD behaviour:
  - `o_ld_ready` = 1.
  - A handshake (`i_ld_valid`&`o_ld_ready`) writes `i_ld_data` to `i_ld_addr` and increments `o_ld_count`.
  - `o_ld_count` saturates at WORD_DEPTH.
  - All CPU `i_ce` activity is ignored: no write, `o_data` unchanged.
- `i_ld_valid` and `i_ld_done` together in one cycle: the word is written and counted, and the state moves to RUN.
- RUN behaviour:
  - `o_ld_ready` = 0; `i_ld_*` are ignored.
  - `i_ce`&`i_we`: `mem[i_addr]` ← `i_data`; `o_data` holds its previous value.
  - `i_ce`&!`i_we`: `o_data` ← `mem[i_addr]`.
  - `i_ce`=0: `o_data` holds.
- Watch register:
  - A RUN-state CPU write with `i_addr`==WATCH_ADDR loads `o_watch` ← `i_data` and pulses `o_watch_vld`.
  - Preload writes never touch the watch register.
- Memory array contents are not reset. Reset mid-operation:
  - returns to LOAD;
  - sets `o_cpu_hold`=1 and `o_ld_count`=0;
  - preserves the stored words, so the CPU can be rerun without reloading.
- No address range check is needed; WORD_DEPTH = 2**ADDR_WIDTH.

## Timing
- Reset values (after the first edge with `reset_n`=0):
  - `o_data`=0, `o_cpu_hold`=1, `o_ld_ready`=1, `o_ld_count`=0, `o_watch`=0, `o_watch_vld`=0.
  - State is LOAD.
- `o_ld_ready` is decoded combinationally from the state register.
- All other outputs are registered.
- Read latency is 1 cycle. Address sampled at edge N; data valid on `o_data` after edge N, stable until the next read edge.
- Write takes effect at the sampling edge. A read of the same address on the next cycle returns the new value.
- Back-to-back reads are supported, one per cycle.
- `o_cpu_hold` falls at the same edge that enters RUN. The CPU's first access is sampled no earlier than the following edge.
- `o_watch` and `o_watch_vld` update at the write edge; `o_watch_vld` is high for exactly one cycle per qualifying write.
- Consecutive watch writes produce consecutive pulses.

## Structure
- Shared package `cpu_mem_pkg` holds:
  - ADDR_WIDTH, WORD_WIDTH, WORD_DEPTH;
  - the default WATCH_ADDR;
  - the state enum {LOAD, RUN}.
- The CPU and testbench import the same package.
- One sub-module, `sram_core`: a single-port synchronous array (one write port, one registered read port, clock-enable on read).
- `mem_responder` muxes the load port and the CPU port onto `sram_core` by state. It also holds the FSM, counter and watch logic.

## Test plan
- Load: after reset, preload words 0x0001@0, 0x0002@1, 0x0003@2; assert done → `o_ld_count`=3, `o_cpu_hold` falls at that edge. Then CPU read at addr 1 → `o_data`=0x0002 one cycle later.
- LOAD isolation: in LOAD, CPU `i_ce`=1, `i_we`=1, addr 5, data 0xBEEF. After RUN, a read of addr 5 returns the preloaded value, not 0xBEEF; `o_data` stays 0 during LOAD.
- Simultaneous valid+done: word 0x00AA@7 with `i_ld_done` in the same cycle → `o_ld_count`=1, state RUN, and a read of addr 7 returns 0x00AA.
- Watch: in RUN, CPU writes 450 (0x01C2) to addr 99 → `o_watch`=450 and `o_watch_vld` high for one cycle. A write to addr 98 produces no pulse.
- Read-after-write: write 0x1234@10 at edge N, read 10 at edge N+1 → `o_data`=0x1234 after N+1. `o_data` is unchanged after the write edge N.
- Reset mid-RUN: pulse `reset_n` low for one edge → `o_cpu_hold`=1, `o_ld_count`=0, `o_watch`=0. Assert done without loading, then read addr 0 → original 0x0001.
